mda_crtc_ctrl: RTL and testbench

CPU-facing configuration and sequencing controller for the text-mode video path. It implements the MC6845-style index/data register pair, the mode-control port and the status port. It double-buffers the display start address so changes take effect only at vertical sync. It also generates the cursor and character blink phases from a frame counter. It sits on the CPU I/O bus in the `iClk` domain and drives static configuration into the character/font pipeline.

---
 rtl/mda_crtc_ctrl_if.sv | 12 +
 rtl/mda_crtc_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mda_crtc_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mda_crtc_ctrl_if.sv
// CPU I/O bus bundle for the MDA CRTC controller: address, write data,
// one-cycle read/write strobes and registered read data.
interface mda_crtc_ctrl_if;
   logic [15:0] iPortAddr;
   logic [7:0]  iData;
   logic        iIoWr;
   logic        iIoRd;
   logic [7:0]  oData;

   modport master (output iPortAddr, iData, iIoWr, iIoRd, input oData);
   modport slave  (input iPortAddr, iData, iIoWr, iIoRd, output oData);
endinterface

// File: rtl/mda_crtc_ctrl.sv
// MC6845-style index/data pair, mode and status ports, vsync-latched start
// address and frame-counter driven cursor/character blink phases.
module mda_crtc_ctrl #(
   parameter logic [15:0] BASE          = 16'h03B0,
   parameter logic [4:0]  CUR_START_RST = 5'd11,
   parameter logic [4:0]  CUR_END_RST   = 5'd12
) (
   input  logic                 iClk,
   input  logic                 iRst,
   mda_crtc_ctrl_if.slave       bus,
   input  logic                 iVSync,
   input  logic                 iBlank,
   output logic [13:0]          oStartAddr,
   output logic [13:0]          oCursorAddr,
   output logic [4:0]           oCursorStart,
   output logic [4:0]           oCursorEnd,
   output logic                 oCursorOn,
   output logic                 oCharBlink,
   output logic                 oVideoEn,
   output logic                 oBlinkEn,
   output logic                 oHiRes
);

   localparam logic [11:0] BASE_HI = BASE[15:4];
   localparam logic [3:0]  BASE_LO = BASE[3:0];

   logic [4:0]  r_index;
   logic [7:0]  r_mode;
   logic [1:0]  r_blink_mode;
   logic [4:0]  r_cur_start;
   logic [4:0]  r_cur_end;
   logic [13:0] r_shadow;
   logic [13:0] r_start;
   logic [13:0] r_cur_addr;
   logic [4:0]  r_fc;
   logic        r_vs_m, r_vs_s, r_vs_d;
   logic        r_bl_m, r_bl_s;
   logic [7:0]  r_data;

   logic        w_hit;
   logic [3:0]  w_off;
   logic        w_vs_rise;
   logic        w_wr_index, w_wr_data, w_wr_mode;
   logic [7:0]  w_crtc_rd;
   logic [7:0]  w_rd;

   assign w_hit      = (bus.iPortAddr[15:4] == BASE_HI);
   assign w_off      = bus.iPortAddr[3:0] - BASE_LO;
   assign w_vs_rise  = r_vs_s & ~r_vs_d;

   assign w_wr_index = bus.iIoWr && w_hit && (w_off == 4'd4 || w_off == 4'd6);
   assign w_wr_data  = bus.iIoWr && w_hit && (w_off == 4'd5 || w_off == 4'd7);
   assign w_wr_mode  = bus.iIoWr && w_hit && (w_off == 4'd8);

   // Only the cursor address registers read back; everything else is write-only.
   always_comb begin
      w_crtc_rd = 8'h00;
      case (r_index)
         5'd14:   w_crtc_rd = {2'b00, r_cur_addr[13:8]};
         5'd15:   w_crtc_rd = r_cur_addr[7:0];
         default: w_crtc_rd = 8'h00;
      endcase
   end

   always_comb begin
      w_rd = 8'hFF;
      case (w_off)
         4'd4, 4'd6: w_rd = {3'b000, r_index};
         4'd5, 4'd7: w_rd = w_crtc_rd;
         4'd8:       w_rd = 8'h00;
         4'd10:      w_rd = {4'hF, r_vs_s, 2'b00, r_bl_s};
         default:    w_rd = 8'hFF;
      endcase
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         r_vs_m <= 1'b0;
         r_vs_s <= 1'b0;
         r_vs_d <= 1'b0;
         r_bl_m <= 1'b0;
         r_bl_s <= 1'b0;
      end else begin
         r_vs_m <= iVSync;
         r_vs_s <= r_vs_m;
         r_vs_d <= r_vs_s;
         r_bl_m <= iBlank;
         r_bl_s <= r_bl_m;
      end
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         r_data <= 8'h00;
      end else if (bus.iIoRd && w_hit) begin
         r_data <= w_rd;
      end
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         r_index <= 5'd0;
         r_mode  <= 8'h00;
      end else begin
         if (w_wr_index) r_index <= bus.iData[4:0];
         if (w_wr_mode)  r_mode  <= bus.iData;
      end
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         r_blink_mode <= 2'b00;
         r_cur_start  <= CUR_START_RST;
         r_cur_end    <= CUR_END_RST;
         r_shadow     <= 14'd0;
         r_cur_addr   <= 14'd0;
      end else if (w_wr_data) begin
         case (r_index)
            5'd10: begin
               r_blink_mode <= bus.iData[6:5];
               r_cur_start  <= bus.iData[4:0];
            end
            5'd11: r_cur_end         <= bus.iData[4:0];
            5'd12: r_shadow[13:8]    <= bus.iData[5:0];
            5'd13: r_shadow[7:0]     <= bus.iData;
            5'd14: r_cur_addr[13:8]  <= bus.iData[5:0];
            5'd15: r_cur_addr[7:0]   <= bus.iData;
            default: ;
         endcase
      end
   end

   // A shadow write landing on the vsync edge is picked up at the next frame.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         r_start <= 14'd0;
         r_fc    <= 5'd0;
      end else if (w_vs_rise) begin
         r_start <= r_shadow;
         r_fc    <= r_fc + 5'd1;
      end
   end

   always_comb begin
      oCursorOn = 1'b1;
      case (r_blink_mode)
         2'b00: oCursorOn = 1'b1;
         2'b01: oCursorOn = 1'b0;
         2'b10: oCursorOn = r_fc[3];
         2'b11: oCursorOn = r_fc[4];
         default: oCursorOn = 1'b1;
      endcase
   end

   assign bus.oData    = r_data;
   assign oStartAddr   = r_start;
   assign oCursorAddr  = r_cur_addr;
   assign oCursorStart = r_cur_start;
   assign oCursorEnd   = r_cur_end;
   assign oCharBlink   = r_fc[4];
   assign oVideoEn     = r_mode[3];
   assign oBlinkEn     = r_mode[5];
   assign oHiRes       = r_mode[0];

endmodule

// File: tb/tb_mda_crtc_ctrl.sv
// Directed bench for mda_crtc_ctrl: register access, vsync-latched start
// address, blink phases and asynchronous reset.
module tb_mda_crtc_ctrl;
   localparam logic [15:0] BASE = 16'h03B0;

   logic        iClk = 1'b0;
   logic        iRst = 1'b1;
   logic        iVSync = 1'b0;
   logic        iBlank = 1'b0;
   logic [13:0] oStartAddr, oCursorAddr;
   logic [4:0]  oCursorStart, oCursorEnd;
   logic        oCursorOn, oCharBlink, oVideoEn, oBlinkEn, oHiRes;

   int checks = 0;
   int failures = 0;
   logic [7:0] rd_val;

   mda_crtc_ctrl_if bus ();

   mda_crtc_ctrl #(
      .BASE          (BASE),
      .CUR_START_RST (5'd11),
      .CUR_END_RST   (5'd12)
   ) dut (
      .iClk         (iClk),
      .iRst         (iRst),
      .bus          (bus),
      .iVSync       (iVSync),
      .iBlank       (iBlank),
      .oStartAddr   (oStartAddr),
      .oCursorAddr  (oCursorAddr),
      .oCursorStart (oCursorStart),
      .oCursorEnd   (oCursorEnd),
      .oCursorOn    (oCursorOn),
      .oCharBlink   (oCharBlink),
      .oVideoEn     (oVideoEn),
      .oBlinkEn     (oBlinkEn),
      .oHiRes       (oHiRes)
   );

   always #5 iClk = ~iClk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic io_wr(input logic [3:0] off, input logic [7:0] d);
      @(negedge iClk);
      bus.iPortAddr = BASE + {12'd0, off};
      bus.iData     = d;
      bus.iIoWr     = 1'b1;
      @(negedge iClk);
      bus.iIoWr     = 1'b0;
   endtask

   task automatic io_rd(input logic [3:0] off, output logic [7:0] d);
      @(negedge iClk);
      bus.iPortAddr = BASE + {12'd0, off};
      bus.iIoRd     = 1'b1;
      @(negedge iClk);
      bus.iIoRd     = 1'b0;
      d = bus.oData;
   endtask

   task automatic crtc_wr(input logic [4:0] idx, input logic [7:0] d);
      io_wr(4'd4, {3'b000, idx});
      io_wr(4'd5, d);
   endtask

   task automatic vs_pulse();
      @(negedge iClk);
      iVSync = 1'b1;
      repeat (4) @(negedge iClk);
      iVSync = 1'b0;
      repeat (4) @(negedge iClk);
   endtask

   task automatic reset_dut();
      @(negedge iClk);
      iRst = 1'b1;
      @(negedge iClk);
      iRst = 1'b0;
   endtask

   initial begin
      bus.iPortAddr = 16'h0000;
      bus.iData     = 8'h00;
      bus.iIoWr     = 1'b0;
      bus.iIoRd     = 1'b0;
      repeat (2) @(negedge iClk);
      iRst = 1'b0;

      chk("rst_odata", {24'd0, bus.oData}, 32'h00);
      io_rd(4'd4, rd_val);  chk("rst_index", {24'd0, rd_val}, 32'h00);
      io_rd(4'd8, rd_val);  chk("rst_mode_rd", {24'd0, rd_val}, 32'h00);
      io_rd(4'd10, rd_val); chk("rst_status", {24'd0, rd_val}, 32'hF0);
      io_rd(4'd1, rd_val);  chk("unmapped_rd", {24'd0, rd_val}, 32'hFF);
      chk("rst_cur_start", {27'd0, oCursorStart}, 32'd11);
      chk("rst_cur_end", {27'd0, oCursorEnd}, 32'd12);
      chk("rst_cur_on", {31'd0, oCursorOn}, 32'd1);
      chk("rst_start", {18'd0, oStartAddr}, 32'd0);

      crtc_wr(5'd14, 8'hFF);
      crtc_wr(5'd15, 8'h34);
      chk("cur_addr", {18'd0, oCursorAddr}, 32'h3F34);
      io_rd(4'd5, rd_val);  chk("rd_r15", {24'd0, rd_val}, 32'h34);
      io_wr(4'd4, 8'd14);
      io_rd(4'd5, rd_val);  chk("rd_r14", {24'd0, rd_val}, 32'h3F);

      crtc_wr(5'd20, 8'hAA);
      io_rd(4'd4, rd_val);  chk("index_hi_rd", {24'd0, rd_val}, 32'h14);
      io_rd(4'd5, rd_val);  chk("data_hi_rd", {24'd0, rd_val}, 32'h00);
      chk("cur_addr_kept", {18'd0, oCursorAddr}, 32'h3F34);

      // Write and read of the index in the same cycle: read sees old value.
      @(negedge iClk);
      bus.iPortAddr = BASE + 16'd4;
      bus.iData     = 8'd13;
      bus.iIoWr     = 1'b1;
      bus.iIoRd     = 1'b1;
      @(negedge iClk);
      bus.iIoWr     = 1'b0;
      bus.iIoRd     = 1'b0;
      chk("wr_rd_same", {24'd0, bus.oData}, 32'h14);
      io_rd(4'd4, rd_val);  chk("wr_rd_after", {24'd0, rd_val}, 32'h0D);
      io_rd(4'd5, rd_val);  chk("rd_r13_zero", {24'd0, rd_val}, 32'h00);

      crtc_wr(5'd12, 8'h01);
      crtc_wr(5'd13, 8'h40);
      chk("start_held", {18'd0, oStartAddr}, 32'd0);
      @(negedge iClk);
      iVSync = 1'b1;
      @(negedge iClk); chk("start_cyc1", {18'd0, oStartAddr}, 32'h0000);
      @(negedge iClk); chk("start_cyc2", {18'd0, oStartAddr}, 32'h0000);
      @(negedge iClk); chk("start_cyc3", {18'd0, oStartAddr}, 32'h0140);
      iVSync = 1'b0;
      repeat (4) @(negedge iClk);

      crtc_wr(5'd12, 8'h02);
      io_wr(4'd4, 8'd13);
      @(negedge iClk);
      iVSync = 1'b1;
      @(negedge iClk);
      @(negedge iClk);
      bus.iPortAddr = BASE + 16'd5;
      bus.iData     = 8'h77;
      bus.iIoWr     = 1'b1;
      @(negedge iClk);
      bus.iIoWr     = 1'b0;
      chk("edge_wr_old", {18'd0, oStartAddr}, 32'h0240);
      iVSync = 1'b0;
      repeat (4) @(negedge iClk);
      vs_pulse();
      chk("edge_wr_new", {18'd0, oStartAddr}, 32'h0277);

      iBlank = 1'b1;
      repeat (3) @(negedge iClk);
      io_rd(4'd10, rd_val); chk("status_blank", {24'd0, rd_val}, 32'hF1);
      iBlank = 1'b0;
      iVSync = 1'b1;
      repeat (3) @(negedge iClk);
      io_rd(4'd10, rd_val); chk("status_vs", {24'd0, rd_val}, 32'hF8);
      iVSync = 1'b0;
      repeat (4) @(negedge iClk);

      reset_dut();
      chk("rst2_start", {18'd0, oStartAddr}, 32'd0);
      crtc_wr(5'd10, 8'h23);
      crtc_wr(5'd11, 8'h07);
      chk("cur_start_wr", {27'd0, oCursorStart}, 32'd3);
      chk("cur_end_wr", {27'd0, oCursorEnd}, 32'd7);
      chk("cur_off_mode", {31'd0, oCursorOn}, 32'd0);

      crtc_wr(5'd10, 8'h40);
      chk("blink_f0_cur", {31'd0, oCursorOn}, 32'd0);
      chk("blink_f0_chr", {31'd0, oCharBlink}, 32'd0);
      for (int k = 1; k <= 16; k++) begin
         vs_pulse();
         chk($sformatf("blink_f%0d_cur", k), {31'd0, oCursorOn}, (k >= 8 && k <= 15) ? 32'd1 : 32'd0);
         chk($sformatf("blink_f%0d_chr", k), {31'd0, oCharBlink}, (k >= 16) ? 32'd1 : 32'd0);
      end
      crtc_wr(5'd10, 8'h60);
      chk("blink_mode11", {31'd0, oCursorOn}, 32'd1);

      crtc_wr(5'd12, 8'h03);
      crtc_wr(5'd13, 8'h00);
      vs_pulse();
      chk("start_pre_rst", {18'd0, oStartAddr}, 32'h0300);
      io_wr(4'd8, 8'h29);
      chk("video_en", {31'd0, oVideoEn}, 32'd1);
      chk("blink_en", {31'd0, oBlinkEn}, 32'd1);
      chk("hi_res", {31'd0, oHiRes}, 32'd1);

      // Reset lands during a mode write, between clock edges.
      @(negedge iClk);
      bus.iPortAddr = BASE + 16'd8;
      bus.iData     = 8'hFF;
      bus.iIoWr     = 1'b1;
      #1 iRst = 1'b1;
      #1;
      chk("async_video_en", {31'd0, oVideoEn}, 32'd0);
      chk("async_blink_en", {31'd0, oBlinkEn}, 32'd0);
      chk("async_hi_res", {31'd0, oHiRes}, 32'd0);
      chk("async_start", {18'd0, oStartAddr}, 32'd0);
      chk("async_cur_start", {27'd0, oCursorStart}, 32'd11);
      @(negedge iClk);
      iRst = 1'b0;
      bus.iIoWr = 1'b0;
      @(negedge iClk);
      chk("no_partial_wr", {31'd0, oVideoEn}, 32'd0);
      io_rd(4'd4, rd_val); chk("rst3_index", {24'd0, rd_val}, 32'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
